// File: rtl/rx_pkg.sv
// rx_pkg: shared types and constants for the receive frame queue.
//   OCT          - bits per byte
//   MAX_LEN_DEF  - default maximum stored bytes per frame
//   desc_t       - frame descriptor {start pointer, length, source MAC}
//   w_state_e    - write (MAC side) FSM states
//   r_state_e    - read (consumer side) FSM states
package rx_pkg;

  localparam int OCT         = 8;
  localparam int MAX_LEN_DEF = 1518;
  localparam int START_W     = 16;
  localparam int LEN_W       = 16;

  typedef struct packed {
    logic [START_W-1:0] start;
    logic [LEN_W-1:0]   len;
    logic [OCT*6-1:0]   mac_src;
  } desc_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_DROP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_FETCH  = 2'd1,
    R_STREAM = 2'd2
  } r_state_e;

endpackage

// File: rtl/rx_frame_ram.sv
// rx_frame_ram: simple dual-port byte RAM for the frame buffer.
//   i_clk            - clock
//   i_we/i_waddr/i_wdata - write port
//   i_re/i_raddr     - synchronous read port (1-cycle latency)
//   o_rdata          - read data; holds its value while i_re is low
module rx_frame_ram #(
  parameter int ADDR_W = 11,
  parameter int DW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DW-1:0]     i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DW-1:0]     o_rdata
);

  logic [DW-1:0] r_mem [2**ADDR_W];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    // Holding the output register when not reading is what lets the
    // stream side stall without a separate skid buffer.
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_frame_queue_ctrl.sv
// rx_frame_queue_ctrl: buffers received MAC frames in a circular byte
// buffer, queues one descriptor per frame and replays frames one at a
// time over a valid/ready byte stream. Frames that do not fit are dropped
// and counted.
//
// Ports:
//   RX_CLK, rst_n          - clock, async active-low reset
//   rx_payload_ipv4        - byte strobe from the MAC
//   rx_payload             - payload byte
//   rx_irq                 - one-cycle end-of-frame pulse
//   rx_mac_src             - source MAC, valid with rx_irq
//   out_valid/out_data/out_last/out_ready - output byte stream
//   out_len, out_mac_src   - descriptor of the frame being streamed
//   frame_pending          - committed frames not yet fully read
//   drop_cnt               - saturating dropped-frame count
//   rx_pending_irq         - level, frame_pending != 0
//   o_dbg_w_state, o_dbg_r_state, o_dbg_used - FSM states and buffer fill
//
// Handshake: a byte transfers on a clock edge where out_valid & out_ready
// are both 1; while out_valid=1 and out_ready=0, out_data and out_last are
// held unchanged and out_valid stays high.
//
// Build option: define RX_FCS_STRIP_EN to strip the trailing 4 FCS bytes
// from every committed frame (they are stored but never streamed).
module rx_frame_queue_ctrl
  import rx_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int NDESC   = 4,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                    RX_CLK,
  input  logic                    rst_n,
  input  logic                    rx_payload_ipv4,
  input  logic [OCT-1:0]          rx_payload,
  input  logic                    rx_irq,
  input  logic [OCT*6-1:0]        rx_mac_src,
  output logic                    out_valid,
  output logic [OCT-1:0]          out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [15:0]             out_len,
  output logic [OCT*6-1:0]        out_mac_src,
  output logic [$clog2(NDESC):0]  frame_pending,
  output logic [15:0]             drop_cnt,
  output logic                    rx_pending_irq,
  output w_state_e                o_dbg_w_state,
  output r_state_e                o_dbg_r_state,
  output logic [ADDR_W:0]         o_dbg_used
);

  localparam int              DQ_AW     = $clog2(NDESC);
  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE   = 1;
  localparam logic [DQ_AW:0]  DQ_ONE    = 1;
  localparam logic [DQ_AW:0]  DQ_DEPTH  = NDESC[DQ_AW:0];
  localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);
`ifdef RX_FCS_STRIP_EN
  localparam logic [15:0]     FCS_LEN   = 16'd4;
`else
  localparam logic [15:0]     FCS_LEN   = 16'd0;
`endif

  // Write side
  w_state_e         r_wstate, w_wstate_nxt;
  logic [ADDR_W:0]  r_wptr, w_wptr_nxt;
  logic [ADDR_W:0]  r_fstart, w_fstart_nxt;
  logic [15:0]      r_flen, w_flen_nxt;
  logic [15:0]      r_drop_cnt;
  logic             w_we;
  logic             w_commit;
  logic             w_drop_inc;

  // Read side
  r_state_e         r_rstate, w_rstate_nxt;
  logic [ADDR_W:0]  r_rptr;
  logic [ADDR_W:0]  w_rptr_p1;
  logic [ADDR_W:0]  w_rptr_pop;
  logic [15:0]      r_rd_idx;
  logic [15:0]      r_out_len;
  logic [OCT*6-1:0] r_out_mac;
  logic             w_load;
  logic             w_re;
  logic [ADDR_W-1:0] w_raddr;
  logic [OCT-1:0]   w_rdata;
  logic             w_accept;
  logic             w_last;
  logic             w_pop;

  // Descriptor queue
  desc_t            r_desc [NDESC];
  logic [DQ_AW:0]   r_dq_wp;
  logic [DQ_AW:0]   r_dq_rp;
  logic [DQ_AW:0]   w_dq_cnt;
  logic             w_dq_full;
  desc_t            w_head;
  desc_t            w_new_desc;

  logic [ADDR_W:0]  w_used;
  logic             w_buf_full;
  logic             w_unused_start;

  assign w_used     = r_wptr - r_rptr;
  assign w_buf_full = (w_used == DEPTH);
  assign w_dq_cnt   = r_dq_wp - r_dq_rp;
  assign w_dq_full  = (w_dq_cnt == DQ_DEPTH);
  assign w_head     = r_desc[r_dq_rp[DQ_AW-1:0]];

  assign w_new_desc.start   = START_W'(r_fstart);
  assign w_new_desc.len     = r_flen - FCS_LEN;
  assign w_new_desc.mac_src = rx_mac_src;

  assign w_unused_start = &{1'b0, w_head.start[START_W-1:ADDR_W+1]};

  // ---------------- write FSM ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wptr_nxt   = r_wptr;
    w_fstart_nxt = r_fstart;
    w_flen_nxt   = r_flen;
    w_we         = 1'b0;
    w_commit     = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (rx_payload_ipv4) begin
          // A full buffer is also refused here so unread bytes are never hit.
          if (w_dq_full || w_buf_full) begin
            w_wstate_nxt = W_DROP;
          end else begin
            w_we         = 1'b1;
            w_fstart_nxt = r_wptr;
            w_wptr_nxt   = r_wptr + PTR_ONE;
            w_flen_nxt   = 16'd1;
            w_wstate_nxt = W_DATA;
          end
        end
      end
      W_DATA: begin
        if (rx_irq) begin
          w_wstate_nxt = W_IDLE;
          if (r_flen > FCS_LEN) begin
            w_commit = 1'b1;
          end else begin
`ifdef RX_FCS_STRIP_EN
            // Nothing left after stripping the FCS: release and count it.
            w_drop_inc = 1'b1;
            w_wptr_nxt = r_fstart;
`endif
          end
        end else if (rx_payload_ipv4) begin
          if (w_buf_full || (r_flen == MAX_LEN_W)) begin
            w_wptr_nxt   = r_fstart;
            w_wstate_nxt = W_DROP;
          end else begin
            w_we       = 1'b1;
            w_wptr_nxt = r_wptr + PTR_ONE;
            w_flen_nxt = r_flen + 16'd1;
          end
        end
      end
      W_DROP: begin
        if (rx_irq) begin
          w_drop_inc   = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate   <= W_IDLE;
      r_wptr     <= '0;
      r_fstart   <= '0;
      r_flen     <= '0;
      r_drop_cnt <= '0;
      r_dq_wp    <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wptr   <= w_wptr_nxt;
      r_fstart <= w_fstart_nxt;
      r_flen   <= w_flen_nxt;
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_commit) r_dq_wp <= r_dq_wp + DQ_ONE;
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (w_commit) r_desc[r_dq_wp[DQ_AW-1:0]] <= w_new_desc;
  end

  // ---------------- read FSM ----------------
  assign w_rptr_p1  = r_rptr + PTR_ONE;
  // Stored FCS bytes are skipped when the frame is popped.
  assign w_rptr_pop = w_rptr_p1 + FCS_LEN[ADDR_W:0];
  assign w_accept   = (r_rstate == R_STREAM) && out_ready;
  assign w_last     = (r_rd_idx == (r_out_len - 16'd1));
  assign w_pop      = w_accept && w_last;

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_load       = 1'b0;
    w_re         = 1'b0;
    w_raddr      = r_rptr[ADDR_W-1:0];
    case (r_rstate)
      R_IDLE: begin
        if (w_dq_cnt != '0) begin
          w_load       = 1'b1;
          w_rstate_nxt = R_FETCH;
        end
      end
      R_FETCH: begin
        w_re         = 1'b1;
        w_rstate_nxt = R_STREAM;
      end
      R_STREAM: begin
        if (out_ready) begin
          if (w_last) begin
            w_rstate_nxt = R_IDLE;
          end else begin
            // Prefetch the following byte so it is ready next cycle.
            w_re    = 1'b1;
            w_raddr = w_rptr_p1[ADDR_W-1:0];
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_rptr    <= '0;
      r_rd_idx  <= '0;
      r_out_len <= '0;
      r_out_mac <= '0;
      r_dq_rp   <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_load) begin
        r_out_len <= w_head.len;
        r_out_mac <= w_head.mac_src;
        r_rptr    <= w_head.start[ADDR_W:0];
        r_rd_idx  <= '0;
      end else if (w_accept) begin
        r_rd_idx <= r_rd_idx + 16'd1;
        r_rptr   <= w_pop ? w_rptr_pop : w_rptr_p1;
      end
      if (w_pop) r_dq_rp <= r_dq_rp + DQ_ONE;
    end
  end

  rx_frame_ram #(
    .ADDR_W (ADDR_W),
    .DW     (OCT)
  ) u_ram (
    .i_clk   (RX_CLK),
    .i_we    (w_we),
    .i_waddr (r_wptr[ADDR_W-1:0]),
    .i_wdata (rx_payload),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign out_valid      = (r_rstate == R_STREAM);
  assign out_data       = out_valid ? w_rdata : '0;
  assign out_last       = out_valid && w_last;
  assign out_len        = r_out_len;
  assign out_mac_src    = r_out_mac;
  assign frame_pending  = w_dq_cnt;
  assign drop_cnt       = r_drop_cnt;
  assign rx_pending_irq = (w_dq_cnt != '0);
  assign o_dbg_w_state  = r_wstate;
  assign o_dbg_r_state  = r_rstate;
  assign o_dbg_used     = w_used;

endmodule

// File: tb/tb_rx_frame_queue_ctrl.sv
// Testbench for rx_frame_queue_ctrl. Two instances share all inputs: the
// default geometry (ADDR_W=11) and a small one (ADDR_W=8) for the buffer
// wrap/overflow cases; sel8 picks which one is observed.
module tb_rx_frame_queue_ctrl;
  import rx_pkg::*;

`ifdef RX_FCS_STRIP_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif

  // ---------------- clock / reset / inputs ----------------
  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        pv        = 1'b0;
  logic [7:0]  pd        = 8'h00;
  logic        irq       = 1'b0;
  logic [47:0] mac       = 48'h0;
  logic        out_ready = 1'b0;
  logic        sel8      = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUT outputs ----------------
  logic a_valid, a_last, a_irq;
  logic [7:0] a_data;
  logic [15:0] a_len, a_drop;
  logic [47:0] a_mac;
  logic [2:0] a_pend;
  w_state_e a_wst;
  r_state_e a_rst;
  logic [11:0] a_used;

  logic b_valid, b_last, b_irq;
  logic [7:0] b_data;
  logic [15:0] b_len, b_drop;
  logic [47:0] b_mac;
  logic [2:0] b_pend;
  w_state_e b_wst;
  r_state_e b_rst;
  logic [8:0] b_used;

  rx_frame_queue_ctrl dut (
    .RX_CLK(clk), .rst_n(rst_n), .rx_payload_ipv4(pv), .rx_payload(pd),
    .rx_irq(irq), .rx_mac_src(mac), .out_valid(a_valid), .out_data(a_data),
    .out_last(a_last), .out_ready(out_ready), .out_len(a_len),
    .out_mac_src(a_mac), .frame_pending(a_pend), .drop_cnt(a_drop),
    .rx_pending_irq(a_irq), .o_dbg_w_state(a_wst), .o_dbg_r_state(a_rst),
    .o_dbg_used(a_used)
  );

  rx_frame_queue_ctrl #(.ADDR_W(8)) dut8 (
    .RX_CLK(clk), .rst_n(rst_n), .rx_payload_ipv4(pv), .rx_payload(pd),
    .rx_irq(irq), .rx_mac_src(mac), .out_valid(b_valid), .out_data(b_data),
    .out_last(b_last), .out_ready(out_ready), .out_len(b_len),
    .out_mac_src(b_mac), .frame_pending(b_pend), .drop_cnt(b_drop),
    .rx_pending_irq(b_irq), .o_dbg_w_state(b_wst), .o_dbg_r_state(b_rst),
    .o_dbg_used(b_used)
  );

  logic m_valid, m_last, m_irq;
  logic [7:0] m_data;
  logic [15:0] m_len, m_drop, m_used;
  logic [47:0] m_mac;
  logic [2:0] m_pend;

  always_comb begin
    if (sel8) begin
      m_valid = b_valid; m_last = b_last; m_irq = b_irq; m_data = b_data;
      m_len = b_len; m_drop = b_drop; m_used = 16'(b_used); m_mac = b_mac;
      m_pend = b_pend;
    end else begin
      m_valid = a_valid; m_last = a_last; m_irq = a_irq; m_data = a_data;
      m_len = a_len; m_drop = a_drop; m_used = 16'(a_used); m_mac = a_mac;
      m_pend = a_pend;
    end
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {last, byte}
  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  logic       hold_pend = 1'b0;
  logic [8:0] hold_v    = 9'h0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sampled mid-cycle: compares accepted bytes and checks stall holding.
  task automatic monitor();
    logic [8:0] e;
    if (m_valid) begin
      if (hold_pend) check("hold", 64'({m_last, m_data}), 64'(hold_v));
      if (out_ready) begin
        check("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", 64'(m_data), 64'(e[7:0]));
          check("last", 64'(m_last), 64'(e[8]));
        end
        n_acc++;
        hold_pend = 1'b0;
      end else begin
        hold_pend = 1'b1;
        hold_v    = {m_last, m_data};
      end
    end else begin
      hold_pend = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int len, input int tag, input bit keep);
    for (int i = 0; i < len; i++) begin
      pv = 1'b1;
      pd = 8'(tag * 7 + i);
      if (keep && (i < len - FCS)) exp_q.push_back({(i == len - FCS - 1), pd});
      tick();
    end
    pv = 1'b0;
  endtask

  // Returns one cycle after the rx_irq cycle (commit edge + #1).
  task automatic send_frame(input int len, input int tag, input logic [47:0] src, input bit keep);
    send_bytes(len, tag, keep);
    mac = src;
    irq = 1'b1;
    tick();
    irq = 1'b0;
  endtask

  task automatic wait_drain(input bit tog, input int budget);
    int k;
    k = 0;
    while (((exp_q.size() != 0) || (m_pend != 3'd0)) && (k < budget)) begin
      if (tog) out_ready = ~out_ready;
      tick();
      k++;
    end
    check("drain_in_budget", 64'(k < budget), 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(a_valid), 64'd0);
    check({tag, "_data"},  64'(a_data),  64'd0);
    check({tag, "_last"},  64'(a_last),  64'd0);
    check({tag, "_len"},   64'(a_len),   64'd0);
    check({tag, "_mac"},   64'(a_mac),   64'd0);
    check({tag, "_pend"},  64'(a_pend),  64'd0);
    check({tag, "_drop"},  64'(a_drop),  64'd0);
    check({tag, "_irq"},   64'(a_irq),   64'd0);
    check({tag, "_wst"},   64'(a_wst),   64'(W_IDLE));
    check({tag, "_rst"},   64'(a_rst),   64'(R_IDLE));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Reset state
    #3;
    check_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // T1: single 60-byte frame, consumer always ready, latency 3
    out_ready = 1'b1;
    n_acc = 0;
    send_frame(60, 1, 48'h02_00_00_00_00_01, 1'b1);
    check("t1_pend1", 64'(m_pend), 64'd1);
    check("t1_irq1", 64'(m_irq), 64'd1);
    check("t1_valid_c1", 64'(m_valid), 64'd0);
    tick();
    check("t1_valid_c2", 64'(m_valid), 64'd0);
    tick();
    check("t1_valid_c3", 64'(m_valid), 64'd1);
    check("t1_len", 64'(m_len), 64'(60 - FCS));
    check("t1_mac", 64'(m_mac), 64'h02_00_00_00_00_01);
    wait_drain(1'b0, 500);
    check("t1_acc", 64'(n_acc), 64'(60 - FCS));
    check("t1_pend0", 64'(m_pend), 64'd0);
    check("t1_irq0", 64'(m_irq), 64'd0);
    check("t1_used0", 64'(m_used), 64'd0);

    // T2: same frame, consumer ready toggling
    n_acc = 0;
    send_frame(60, 2, 48'h02_00_00_00_00_02, 1'b1);
    wait_drain(1'b1, 1000);
    check("t2_acc", 64'(n_acc), 64'(60 - FCS));
    check("t2_mac", 64'(m_mac), 64'h02_00_00_00_00_02);

    // T3: 5 back-to-back 64-byte frames while stalled; 5th dropped
    out_ready = 1'b0;
    n_acc = 0;
    for (int f = 0; f < 5; f++) send_frame(64, 10 + f, 48'h0A_00_00_00_00_00 + 48'(f), f < 4);
    check("t3_pend4", 64'(m_pend), 64'd4);
    check("t3_drop1", 64'(m_drop), 64'd1);
    check("t3_irq", 64'(m_irq), 64'd1);
    check("t3_len", 64'(m_len), 64'(64 - FCS));
    out_ready = 1'b1;
    wait_drain(1'b0, 2000);
    check("t3_acc", 64'(n_acc), 64'(4 * (64 - FCS)));
    check("t3_used0", 64'(m_used), 64'd0);
    check("t3_mac_last", 64'(m_mac), 64'h0A_00_00_00_00_03);

    // T4: 1518-byte frame accepted, 1519-byte frame dropped
    n_acc = 0;
    send_frame(1518, 20, 48'h02_00_00_00_00_14, 1'b1);
    send_frame(1519, 21, 48'h02_00_00_00_00_15, 1'b0);
    check("t4_drop2", 64'(m_drop), 64'd2);
    wait_drain(1'b0, 4000);
    check("t4_acc", 64'(n_acc), 64'(1518 - FCS));
    check("t4_len", 64'(m_len), 64'(1518 - FCS));
    check("t4_pend0", 64'(m_pend), 64'd0);
    check("t4_used0", 64'(m_used), 64'd0);

    // T5: async reset with a stalled frame and a frame in flight
    out_ready = 1'b0;
    send_frame(40, 30, 48'h02_00_00_00_00_1E, 1'b1);
    send_bytes(20, 31, 1'b0);
    pv = 1'b1;
    check("t5_pre_valid", 64'(m_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t5_rst");
    exp_q.delete();
    hold_pend = 1'b0;
    pv = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    n_acc = 0;
    send_frame(60, 32, 48'h02_00_00_00_00_20, 1'b1);
    wait_drain(1'b0, 500);
    check("t5_acc", 64'(n_acc), 64'(60 - FCS));
    check("t5_drop0", 64'(m_drop), 64'd0);

    // T6: ADDR_W=8 instance: overflow drop with rewind, then wrap
    sel8 = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_wst", 64'(b_wst), 64'(W_IDLE));
    check("t6_rst", 64'(b_rst), 64'(R_IDLE));
    out_ready = 1'b0;
    n_acc = 0;
    send_frame(200, 40, 48'h02_00_00_00_00_28, 1'b1);
    send_frame(100, 41, 48'h02_00_00_00_00_29, 1'b0);
    check("t6_drop1", 64'(m_drop), 64'd1);
    check("t6_pend1", 64'(m_pend), 64'd1);
    check("t6_used_rewind", 64'(m_used), 64'd200);
    out_ready = 1'b1;
    wait_drain(1'b0, 1000);
    check("t6_acc1", 64'(n_acc), 64'(200 - FCS));
    check("t6_used0", 64'(m_used), 64'd0);
    n_acc = 0;
    send_frame(150, 42, 48'h02_00_00_00_00_2A, 1'b1);
    wait_drain(1'b0, 1000);
    check("t6_acc_wrap", 64'(n_acc), 64'(150 - FCS));
    check("t6_len_wrap", 64'(m_len), 64'(150 - FCS));
    check("t6_used_end", 64'(m_used), 64'd0);
    check("t6_drop_end", 64'(m_drop), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
